// File: rtl/gcm_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// gcm_frame_sequencer_if
// Bundles every non-clock/reset signal of the GCM frame sequencer.
//   master : the sequencer side (drives pops, pushes, AES and GHASH requests)
//   slave  : the surrounding FIFOs, AES block engine and GHASH unit
// Signals:
//   keyReady          round keys loaded; gates the start of a frame
//   rxEmpty/rxData    rx FIFO status and first-word-fall-through head
//   rxPop             consume rx head this cycle
//   txFull/txData     tx FIFO status and write word
//   txPush            write txData this cycle
//   aesStart/aesIn    one-cycle block-encrypt request and its input block
//   aesDone/aesOut    one-cycle completion pulse and E(K, aesIn)
//   ghValid/ghData    GHASH input block and its valid
//   ghLast            marks the length block
//   ghReady           GHASH accepts on ghValid & ghReady
//   ghS/ghSValid      GHASH result and its one-cycle valid pulse
//   finish            one-cycle pulse after the tag has been pushed
//   busy              sequencer is not idle
// ---------------------------------------------------------------------------
interface gcm_frame_sequencer_if;
    logic         keyReady;
    logic         rxEmpty;
    logic [127:0] rxData;
    logic         rxPop;
    logic         txFull;
    logic [127:0] txData;
    logic         txPush;
    logic         aesStart;
    logic [127:0] aesIn;
    logic         aesDone;
    logic [127:0] aesOut;
    logic         ghValid;
    logic [127:0] ghData;
    logic         ghLast;
    logic         ghReady;
    logic [127:0] ghS;
    logic         ghSValid;
    logic         finish;
    logic         busy;

    modport master (
        input  keyReady, rxEmpty, rxData, txFull, aesDone, aesOut,
               ghReady, ghS, ghSValid,
        output rxPop, txData, txPush, aesStart, aesIn, ghValid, ghData,
               ghLast, finish, busy
    );

    modport slave (
        output keyReady, rxEmpty, rxData, txFull, aesDone, aesOut,
               ghReady, ghS, ghSValid,
        input  rxPop, txData, txPush, aesStart, aesIn, ghValid, ghData,
               ghLast, finish, busy
    );
endinterface

// File: rtl/gcm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// gcm_frame_sequencer
// Sequences one AES-GCM encryption frame: reads the IV / AAD-count / PT-count
// header from the rx FIFO, encrypts J0, streams AAD into GHASH, runs CTR mode
// over the plaintext blocks (ciphertext to both tx FIFO and GHASH), feeds the
// length block and finally pushes tag = S ^ E(K, J0). Full blocks only.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any frame in progress
//   bus  gcm_frame_sequencer_if.master (FIFO, AES and GHASH handshakes)
// ---------------------------------------------------------------------------
module gcm_frame_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    gcm_frame_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        IDLE, HDR_IV, HDR_AAD, HDR_PT, EJ0_REQ, EJ0_WAIT, AAD,
        PT_REQ, PT_WAIT, PT_RX, PT_OUT, LEN, TAG_WAIT, TAG_OUT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [95:0]        iv_q, iv_d;
    logic [CNT_W-1:0]   aadCnt_q, aadCnt_d;
    logic [CNT_W-1:0]   ptCnt_q, ptCnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;      // blocks left in the current AAD or PT phase
    logic [127:0]       ctr_q, ctr_d;
    logic [127:0]       ej0_q, ej0_d;
    logic [127:0]       blk_q, blk_d;      // keystream, then ciphertext, then tag
    logic               txDone_q, txDone_d;
    logic               ghDone_q, ghDone_d;
    logic [63:0]        aadBits, ptBits;
    logic               txOk, ghOk;

    // GCM inc32: only the low word counts, wrapping mod 2^32.
    function automatic logic [127:0] inc32(input logic [127:0] c);
        return {c[127:32], c[31:0] + 32'd1};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            iv_q     <= '0;
            aadCnt_q <= '0;
            ptCnt_q  <= '0;
            rem_q    <= '0;
            ctr_q    <= '0;
            ej0_q    <= '0;
            blk_q    <= '0;
            txDone_q <= 1'b0;
            ghDone_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            iv_q     <= iv_d;
            aadCnt_q <= aadCnt_d;
            ptCnt_q  <= ptCnt_d;
            rem_q    <= rem_d;
            ctr_q    <= ctr_d;
            ej0_q    <= ej0_d;
            blk_q    <= blk_d;
            txDone_q <= txDone_d;
            ghDone_q <= ghDone_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        iv_d         = iv_q;
        aadCnt_d     = aadCnt_q;
        ptCnt_d      = ptCnt_q;
        rem_d        = rem_q;
        ctr_d        = ctr_q;
        ej0_d        = ej0_q;
        blk_d        = blk_q;
        txDone_d     = txDone_q;
        ghDone_d     = ghDone_q;
        bus.rxPop    = 1'b0;
        bus.txData   = '0;
        bus.txPush   = 1'b0;
        bus.aesStart = 1'b0;
        bus.aesIn    = '0;
        bus.ghValid  = 1'b0;
        bus.ghData   = '0;
        bus.ghLast   = 1'b0;
        bus.finish   = 1'b0;
        bus.busy     = (state_q != IDLE);
        aadBits      = 64'(aadCnt_q) << 7;
        ptBits       = 64'(ptCnt_q) << 7;
        txOk         = txDone_q || !bus.txFull;
        ghOk         = ghDone_q || bus.ghReady;

        case (state_q)
            IDLE: begin
                if (bus.keyReady && !bus.rxEmpty) state_d = HDR_IV;
            end
            HDR_IV: begin
                if (!bus.rxEmpty) begin
                    bus.rxPop = 1'b1;
                    iv_d      = bus.rxData[127:32];
                    state_d   = HDR_AAD;
                end
            end
            HDR_AAD: begin
                if (!bus.rxEmpty) begin
                    bus.rxPop = 1'b1;
                    aadCnt_d  = bus.rxData[CNT_W-1:0];
                    state_d   = HDR_PT;
                end
            end
            HDR_PT: begin
                if (!bus.rxEmpty) begin
                    bus.rxPop = 1'b1;
                    ptCnt_d   = bus.rxData[CNT_W-1:0];
                    state_d   = EJ0_REQ;
                end
            end
            EJ0_REQ: begin
                bus.aesStart = 1'b1;
                bus.aesIn    = {iv_q, 32'h1};
                state_d      = EJ0_WAIT;
            end
            EJ0_WAIT: begin
                if (bus.aesDone) begin
                    ej0_d = bus.aesOut;
                    ctr_d = {iv_q, 32'h2};
                    if (aadCnt_q != '0) begin
                        rem_d   = aadCnt_q;
                        state_d = AAD;
                    end else if (ptCnt_q != '0) begin
                        rem_d   = ptCnt_q;
                        state_d = PT_REQ;
                    end else begin
                        state_d = LEN;
                    end
                end
            end
            AAD: begin
                // AAD goes straight from the rx head into GHASH; the pop is the handshake.
                if (!bus.rxEmpty) begin
                    bus.ghValid = 1'b1;
                    bus.ghData  = bus.rxData;
                    if (bus.ghReady) begin
                        bus.rxPop = 1'b1;
                        rem_d     = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            if (ptCnt_q != '0) begin
                                rem_d   = ptCnt_q;
                                state_d = PT_REQ;
                            end else begin
                                state_d = LEN;
                            end
                        end
                    end
                end
            end
            PT_REQ: begin
                bus.aesStart = 1'b1;
                bus.aesIn    = ctr_q;
                ctr_d        = inc32(ctr_q);
                state_d      = PT_WAIT;
            end
            PT_WAIT: begin
                // aesOut is only valid during the pulse, so park the keystream.
                if (bus.aesDone) begin
                    blk_d   = bus.aesOut;
                    state_d = PT_RX;
                end
            end
            PT_RX: begin
                if (!bus.rxEmpty) begin
                    bus.rxPop = 1'b1;
                    blk_d     = blk_q ^ bus.rxData;
                    state_d   = PT_OUT;
                end
            end
            PT_OUT: begin
                // tx push and GHASH handshake complete independently; each is
                // issued at most once per block thanks to its done flag.
                bus.txData  = blk_q;
                bus.txPush  = !txDone_q && !bus.txFull;
                bus.ghData  = blk_q;
                bus.ghValid = !ghDone_q;
                if (txOk && ghOk) begin
                    txDone_d = 1'b0;
                    ghDone_d = 1'b0;
                    rem_d    = rem_q - CNT_W'(1);
                    state_d  = (rem_q == CNT_W'(1)) ? LEN : PT_REQ;
                end else begin
                    txDone_d = txOk;
                    ghDone_d = ghOk;
                end
            end
            LEN: begin
                bus.ghValid = 1'b1;
                bus.ghLast  = 1'b1;
                bus.ghData  = {aadBits, ptBits};
                if (bus.ghReady) state_d = TAG_WAIT;
            end
            TAG_WAIT: begin
                if (bus.ghSValid) begin
                    blk_d   = bus.ghS ^ ej0_q;
                    state_d = TAG_OUT;
                end
            end
            TAG_OUT: begin
                bus.txData = blk_q;
                bus.txPush = !bus.txFull;
                if (!bus.txFull) state_d = DONE;
            end
            DONE: begin
                bus.finish = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gcm_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_gcm_frame_sequencer
// Scoreboard bench: each frame's expected AES requests, GHASH blocks and tx
// words are queued when the frame is loaded into the rx FIFO model, and are
// popped and compared as the sequencer produces them. The bench also models
// the AES engine (fixed latency, simple keyed permutation) and the GHASH
// unit (returns a chosen S after the length block).
// ---------------------------------------------------------------------------
module tb_gcm_frame_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    gcm_frame_sequencer_if bus();

    gcm_frame_sequencer #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int nCmp = 0;
    int nErr = 0;

    logic [127:0] rxQ[$];
    logic [127:0] pay[$];
    logic [127:0] expAes[$];
    logic [127:0] expTx[$];
    logic [128:0] expGh[$];
    logic [127:0] frameGhs = '0;
    logic [127:0] ghsCur   = '0;
    logic [127:0] aesReq   = '0;
    logic [127:0] ghHeldData = '0;
    int  aesLat = 1;
    int  aesCnt = 0;
    int  ghsCnt = 0;
    bit  popPend = 0, ghHeld = 0, prevFinish = 0;
    bit  txRand = 0, txForce = 0, ghRand = 0, ghForceLow = 0, rxRand = 0, bogusArm = 0;
    int  finishCnt = 0, popCnt = 0, ghHs = 0, txPushCnt = 0, aesStartCnt = 0;

    function automatic logic [127:0] aes_model(input logic [127:0] x);
        return {x[114:0], x[127:115]} ^ 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk_eq(input string tag, input logic [128:0] act, input logic [128:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_ctl"}, 129'({bus.rxPop, bus.txPush, bus.aesStart, bus.ghValid,
                                    bus.ghLast, bus.finish, bus.busy}), 129'(0));
        chk_eq({tag, "_txData"}, 129'(bus.txData), 129'(0));
        chk_eq({tag, "_aesIn"},  129'(bus.aesIn),  129'(0));
        chk_eq({tag, "_ghData"}, 129'(bus.ghData), 129'(0));
    endtask

    // Load header + payload (pay: AAD blocks then PT blocks) and queue expectations.
    // PT block k uses counter low word 2 for k=0 and lo1+(k-1) afterwards.
    task automatic send_frame(input logic [95:0] iv, input int nA, input int nP,
                              input logic [31:0] lo1, input logic [127:0] ghs);
        logic [127:0] w, c, ct;
        logic [63:0]  la, lp;
        frameGhs = ghs;
        rxQ.push_back({iv, $urandom()});
        w = rnd128(); w[15:0] = 16'(nA); rxQ.push_back(w);
        w = rnd128(); w[15:0] = 16'(nP); rxQ.push_back(w);
        expAes.push_back({iv, 32'h1});
        for (int i = 0; i < nA; i++) begin
            rxQ.push_back(pay[i]);
            expGh.push_back({1'b0, pay[i]});
        end
        for (int k = 0; k < nP; k++) begin
            c  = {iv, (k == 0) ? 32'd2 : lo1 + 32'(k - 1)};
            ct = pay[nA + k] ^ aes_model(c);
            expAes.push_back(c);
            rxQ.push_back(pay[nA + k]);
            expGh.push_back({1'b0, ct});
            expTx.push_back(ct);
        end
        la = 64'(nA) << 7;
        lp = 64'(nP) << 7;
        expGh.push_back({1'b1, la, lp});
        expTx.push_back(ghs ^ aes_model({iv, 32'h1}));
    endtask

    task automatic wait_frame(input string tag);
        int start;
        start = finishCnt;
        for (int i = 0; i < 600 && finishCnt == start; i++) tick();
        chk_eq({tag, "_done"},    129'(finishCnt),     129'(start + 1));
        chk_eq({tag, "_txLeft"},  129'(expTx.size()),  129'(0));
        chk_eq({tag, "_ghLeft"},  129'(expGh.size()),  129'(0));
        chk_eq({tag, "_aesLeft"}, 129'(expAes.size()), 129'(0));
        chk_eq({tag, "_rxLeft"},  129'(rxQ.size()),    129'(0));
    endtask

    // Environment: FIFO / AES / GHASH models (after posedge), monitor (negedge).
    initial begin
        bus.rxEmpty = 1'b1; bus.rxData = '0; bus.txFull = 1'b0;
        bus.aesDone = 1'b0; bus.aesOut = '0; bus.ghReady = 1'b1;
        bus.ghS = '0; bus.ghSValid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                popPend = 0; aesCnt = 0; ghsCnt = 0; ghHeld = 0;
            end
            if (popPend && rxQ.size() > 0) void'(rxQ.pop_front());
            popPend = 0;
            bus.aesDone  = 1'b0;
            bus.ghSValid = 1'b0;
            if (aesCnt > 0) begin
                aesCnt--;
                if (aesCnt == 0) begin
                    bus.aesDone = 1'b1;
                    bus.aesOut  = aes_model(aesReq);
                end
            end
            if (ghsCnt > 0) begin
                ghsCnt--;
                if (ghsCnt == 0) begin
                    bus.ghSValid = 1'b1;
                    bus.ghS      = ghsCur;
                end
            end
            bus.rxEmpty = (rxQ.size() == 0) || (rxRand && $urandom_range(0, 3) == 0);
            bus.rxData  = (rxQ.size() > 0) ? rxQ[0] : '0;
            bus.txFull  = txForce || (txRand && $urandom_range(0, 2) == 0);
            bus.ghReady = !ghForceLow && !(ghRand && $urandom_range(0, 2) == 0);

            @(negedge clk);
            if (!rst) begin
                if (bus.rxPop) begin
                    chk_eq("rxPop_vs_empty", 129'(bus.rxEmpty), 129'(0));
                    popPend = 1;
                    popCnt++;
                end
                if (bus.txFull && bus.txData != '0 && expTx.size() > 0)
                    chk_eq("txData_hold", 129'(bus.txData), 129'(expTx[0]));
                if (bus.txPush) begin
                    txPushCnt++;
                    chk_eq("txPush_vs_full", 129'(bus.txFull), 129'(0));
                    if (expTx.size() == 0) chk_eq("tx_unexpected", 129'(expTx.size()), 129'(1));
                    else chk_eq("txData", 129'(bus.txData), 129'(expTx.pop_front()));
                end
                if (bus.aesStart) begin
                    aesStartCnt++;
                    aesReq = bus.aesIn;
                    aesCnt = aesLat;
                    if (expAes.size() == 0) chk_eq("aes_unexpected", 129'(expAes.size()), 129'(1));
                    else chk_eq("aesIn", 129'(bus.aesIn), 129'(expAes.pop_front()));
                end
                if (bus.ghValid) begin
                    if (ghHeld) chk_eq("ghData_hold", 129'(bus.ghData), 129'(ghHeldData));
                    if (bus.ghReady) begin
                        ghHs++;
                        ghHeld = 0;
                        if (expGh.size() == 0) chk_eq("gh_unexpected", 129'(expGh.size()), 129'(1));
                        else chk_eq("ghData", {bus.ghLast, bus.ghData}, expGh.pop_front());
                        if (bus.ghLast) begin
                            ghsCur = frameGhs; ghsCnt = 3;
                        end else if (bogusArm) begin
                            ghsCur = ~frameGhs; ghsCnt = 1; bogusArm = 0;
                        end
                    end else begin
                        ghHeld = 1;
                        ghHeldData = bus.ghData;
                    end
                end else begin
                    ghHeld = 0;
                end
                if (bus.finish) begin
                    chk_eq("finish_pulse", 129'(prevFinish), 129'(0));
                    finishCnt++;
                end
                prevFinish = bus.finish;
            end
        end
    end

    initial begin
        int p0, t0, a0, h0;
        logic [95:0] iv;
        bus.keyReady = 1'b0;
        #1 rst = 1'b1;
        tick(); tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();

        // Frame 1: no AAD, three PT blocks.
        bus.keyReady = 1'b1;
        iv = 96'hcafebabefacedbaddecaf888;
        pay.delete();
        pay.push_back(128'hfeedfacedeadbeeffeedfacedeadbeef);
        pay.push_back(128'habaddad2abaddad2abaddad2abaddad2);
        pay.push_back(128'hd9313225f88406e5a55909c5aff5269a);
        send_frame(iv, 0, 3, 32'd3, 128'h0388dace60b6a392f328c2b971b2fe78);
        wait_frame("f1_pt3");

        // Frame 2: two AAD, one PT, random stalls, early ghSValid pulse.
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(rnd128());
        rxRand = 1; txRand = 1; ghRand = 1; bogusArm = 1;
        send_frame(96'h0123456789abcdef01234567, 2, 1, 32'd3, rnd128());
        wait_frame("f2_aad2");
        rxRand = 0; txRand = 0; ghRand = 0; bogusArm = 0;

        // Frame 3: empty frame -> only headers popped, only the tag pushed.
        p0 = popCnt; t0 = txPushCnt;
        pay.delete();
        send_frame(96'hfedcba9876543210aa55aa55, 0, 0, 32'd3, rnd128());
        wait_frame("f3_empty");
        chk_eq("f3_pops",   129'(popCnt - p0),    129'(3));
        chk_eq("f3_pushes", 129'(txPushCnt - t0), 129'(1));

        // Frame 4: txFull held during PT_OUT; keyReady dropped mid-frame.
        p0 = popCnt; t0 = txPushCnt; h0 = ghHs;
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(rnd128());
        txForce = 1;
        send_frame(96'h111122223333444455556666, 1, 2, 32'd3, rnd128());
        for (int i = 0; i < 200 && ghHs < h0 + 2; i++) tick();
        chk_eq("f4_ghHs", 129'(ghHs), 129'(h0 + 2));
        bus.keyReady = 1'b0;
        repeat (5) tick();
        chk_eq("f4_noPush", 129'(txPushCnt), 129'(t0));
        chk_eq("f4_pops",   129'(popCnt - p0), 129'(5));
        txForce = 0;
        wait_frame("f4_txhold");
        bus.keyReady = 1'b1;

        // Frame 5: ghReady held low while the first ciphertext waits in PT_OUT.
        p0 = popCnt; t0 = txPushCnt;
        pay.delete();
        for (int i = 0; i < 2; i++) pay.push_back(rnd128());
        ghForceLow = 1;
        send_frame(96'h777788889999aaaabbbbcccc, 0, 2, 32'd3, rnd128());
        for (int i = 0; i < 200 && txPushCnt < t0 + 1; i++) tick();
        chk_eq("f5_push", 129'(txPushCnt), 129'(t0 + 1));
        repeat (5) tick();
        chk_eq("f5_pushHeld", 129'(txPushCnt), 129'(t0 + 1));
        chk_eq("f5_pops",     129'(popCnt - p0), 129'(4));
        ghForceLow = 0;
        wait_frame("f5_ghhold");

        // Frame 6: counter forced to a 2^32 boundary after the first PT request.
        aesLat = 4;
        a0 = aesStartCnt;
        iv = 96'h0badc0de0badc0de0badc0de;
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(rnd128());
        send_frame(iv, 0, 3, 32'hffffffff, rnd128());
        for (int i = 0; i < 200 && aesStartCnt < a0 + 2; i++) tick();
        chk_eq("f6_req", 129'(aesStartCnt), 129'(a0 + 2));
        @(posedge clk);
        #2 force dut.ctr_q = {iv, 32'hffffffff};
        @(negedge clk);
        @(negedge clk);
        release dut.ctr_q;
        wait_frame("f6_wrap");

        // Frame 7: reset while waiting for the AES engine in PT_WAIT.
        aesLat = 8;
        a0 = aesStartCnt;
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(rnd128());
        send_frame(96'h5a5a5a5a5a5a5a5a5a5a5a5a, 1, 2, 32'd3, rnd128());
        for (int i = 0; i < 200 && aesStartCnt < a0 + 2; i++) tick();
        chk_eq("f7_req", 129'(aesStartCnt), 129'(a0 + 2));
        tick(); tick();
        chk_eq("f7_busy", 129'(bus.busy), 129'(1));
        rst = 1'b1;
        #1;
        chk_idle("rst_ptwait");
        rxQ.delete(); expAes.delete(); expTx.delete(); expGh.delete();
        tick(); tick();
        rst = 1'b0;
        aesLat = 2;

        // Frame 8: waits in IDLE while keyReady is low, then completes.
        bus.keyReady = 1'b0;
        pay.delete();
        for (int i = 0; i < 3; i++) pay.push_back(rnd128());
        p0 = popCnt;
        send_frame(96'hdeadbeef00112233cafef00d, 1, 2, 32'd3, rnd128());
        repeat (10) tick();
        chk_eq("f8_idleBusy", 129'(bus.busy),  129'(0));
        chk_eq("f8_idlePop",  129'(bus.rxPop), 129'(0));
        chk_eq("f8_noPops",   129'(popCnt),    129'(p0));
        bus.keyReady = 1'b1;
        wait_frame("f8_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
